// File: rtl/narrow_16to12.sv
// Width-narrowing unit: takes IN_W-bit values, emits the low OUT_W bits through a
// 2-entry FIFO, flags lossy narrowings and keeps sticky/saturating loss statistics.
module narrow_16to12 #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 12,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_lossy,
  output logic             lossy_sticky,
  output logic [CNT_W-1:0] lossy_count,
  input  logic             clr_stats
);

  localparam int UP_W = IN_W - OUT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Signed check: discarded upper bits must replicate the new sign bit.
  function automatic logic lossy_of(input logic [IN_W-1:0] d, input logic s);
    logic [UP_W-1:0] up;
    up = d[IN_W-1:OUT_W];
    if (s) begin
      lossy_of = (up != {UP_W{d[OUT_W-1]}});
    end else begin
      lossy_of = (up != {UP_W{1'b0}});
    end
  endfunction

  logic             head_valid_r, skid_valid_r;
  logic [OUT_W-1:0] head_data_r, skid_data_r;
  logic             head_lossy_r, skid_lossy_r;
  logic             sticky_r;
  logic [CNT_W-1:0] count_r;

  logic             head_valid_s, skid_valid_s;
  logic [OUT_W-1:0] head_data_s, skid_data_s;
  logic             head_lossy_s, skid_lossy_s;
  logic             sticky_s;
  logic [CNT_W-1:0] count_s, count_base_s;
  logic             push_s, pop_s, in_lossy_s;

  assign in_ready   = !(head_valid_r && skid_valid_r);
  assign push_s     = in_valid && in_ready;
  assign pop_s      = head_valid_r && out_ready;
  assign in_lossy_s = lossy_of(in_data, in_signed);

  // FIFO next state: head register feeds the outputs, skid holds the second entry.
  always_comb begin
    head_valid_s = head_valid_r;
    head_data_s  = head_data_r;
    head_lossy_s = head_lossy_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    skid_lossy_s = skid_lossy_r;
    case ({head_valid_r, skid_valid_r})
      2'b00: begin
        if (push_s) begin
          head_valid_s = 1'b1;
          head_data_s  = in_data[OUT_W-1:0];
          head_lossy_s = in_lossy_s;
        end else begin
          head_valid_s = 1'b0;
        end
      end
      2'b10: begin
        if (push_s && pop_s) begin
          head_data_s  = in_data[OUT_W-1:0];
          head_lossy_s = in_lossy_s;
        end else if (push_s) begin
          skid_valid_s = 1'b1;
          skid_data_s  = in_data[OUT_W-1:0];
          skid_lossy_s = in_lossy_s;
        end else if (pop_s) begin
          head_valid_s = 1'b0;
        end else begin
          head_valid_s = 1'b1;
        end
      end
      2'b11: begin
        if (pop_s) begin
          head_data_s  = skid_data_r;
          head_lossy_s = skid_lossy_r;
          skid_valid_s = 1'b0;
        end else begin
          skid_valid_s = 1'b1;
        end
      end
      default: begin
        head_valid_s = 1'b0;
        skid_valid_s = 1'b0;
      end
    endcase
  end

  // Statistics: clear is applied first, then a lossy accept counts on top of it.
  always_comb begin
    count_base_s = clr_stats ? {CNT_W{1'b0}} : count_r;
    if (push_s && in_lossy_s) begin
      sticky_s = 1'b1;
      count_s  = (count_base_s == CNT_MAX) ? CNT_MAX : count_base_s + CNT_ONE;
    end else begin
      sticky_s = clr_stats ? 1'b0 : sticky_r;
      count_s  = count_base_s;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      head_valid_r <= 1'b0;
      head_data_r  <= {OUT_W{1'b0}};
      head_lossy_r <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= {OUT_W{1'b0}};
      skid_lossy_r <= 1'b0;
      sticky_r     <= 1'b0;
      count_r      <= {CNT_W{1'b0}};
    end else begin
      head_valid_r <= head_valid_s;
      head_data_r  <= head_data_s;
      head_lossy_r <= head_lossy_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      skid_lossy_r <= skid_lossy_s;
      sticky_r     <= sticky_s;
      count_r      <= count_s;
    end
  end

  assign out_valid    = head_valid_r;
  assign out_data     = head_data_r;
  assign out_lossy    = head_lossy_r;
  assign lossy_sticky = sticky_r;
  assign lossy_count  = count_r;

endmodule
